// File: rtl/uart_tx.sv
// UART transmitter with an integrated TX FIFO: LSB-first frames of start, data, [parity], stop bit(s).
// Define UART_TX_PARITY_EN to add one even parity bit after the data bits.
module uart_tx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] d_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 full,
    output logic                 empty,
    output logic                 fifo_overflow
);

    localparam int BAUD_DIV = CLOCK_FREQ / BAUD;
    localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int BIT_W    = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state, w_state_next;
    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr, r_rd_ptr;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_BITS-1:0]  r_shift, w_shift_next;
    logic                  r_parity;
    logic                  r_tx, r_busy, r_overflow;
    logic                  w_tx_d, w_busy_d;
    logic                  w_empty, w_full, w_pop, w_push, w_baud_done;
    logic [DATA_BITS-1:0]  w_head;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    // A pop on the same edge frees a slot, so a write while full is still accepted.
    assign w_push      = wr_en && (!w_full || w_pop);
    assign w_baud_done = (r_baud == BAUD_W'(BAUD_DIV - 1));

    // NOTE: the FIFO storage has no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= d_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_overflow <= wr_en && w_full && !w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) begin
                w_state_next = S_START;
                w_pop        = 1'b1;
            end
            S_START: if (w_baud_done) w_state_next = S_DATA;
            S_DATA: if (w_baud_done && r_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                w_state_next = S_PARITY;
`else
                w_state_next = S_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (w_baud_done) w_state_next = S_STOP;
`endif
            S_STOP: if (w_baud_done && r_bit == BIT_W'(STOP_BITS - 1)) begin
                if (!w_empty) begin
                    w_state_next = S_START;
                    w_pop        = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift_next = r_shift;
        if (w_pop)                                  w_shift_next = w_head;
        else if (r_state == S_DATA && w_baud_done)  w_shift_next = r_shift >> 1;
    end

    // Line level is decoded from the upcoming state so tx leaves a flop aligned with the state change.
    always_comb begin
        w_tx_d   = 1'b1;
        w_busy_d = (w_state_next != S_IDLE);
        case (w_state_next)
            S_START:  w_tx_d = 1'b0;
            S_DATA:   w_tx_d = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_d = r_parity;
`endif
            default:  w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_baud_done) r_baud <= '0;
            else                                  r_baud <= r_baud + 1'b1;
            if (w_state_next != r_state) r_bit <= '0;
            else if (w_baud_done)        r_bit <= r_bit + 1'b1;
            r_shift <= w_shift_next;
            if (w_pop) r_parity <= ^w_head;
            r_tx   <= w_tx_d;
            r_busy <= w_busy_d;
        end
    end

    assign tx            = r_tx;
    assign tx_busy       = r_busy;
    assign full          = w_full;
    assign empty         = w_empty;
    assign fifo_overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_DIV=10; frames are sampled at bit centres and compared to hand-built frames.
// Honours UART_TX_PARITY_EN (then runs with STOP_BITS=2).
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P      = 1;
    localparam int STOP_N = 2;
`else
    localparam int P      = 0;
    localparam int STOP_N = 1;
`endif
    localparam int D          = 10;
    localparam int NBITS      = 1 + 8 + P + STOP_N;
    localparam int FRAME_CYC  = NBITS * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] d_in = '0;
    logic       tx, tx_busy, full, empty, fifo_overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    uart_tx #(
        .CLOCK_FREQ(1_000_000),
        .BAUD      (100_000),
        .DATA_BITS (8),
        .STOP_BITS (STOP_N),
        .FIFO_DEPTH(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .d_in         (d_in),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .full         (full),
        .empty        (empty),
        .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: bit k of the result is the line level during bit period k.
    function automatic logic [15:0] frame_of(input logic [7:0] b);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[1 + k] = b[k];
        if (P == 1) f[9] = ^b;
        for (int k = NBITS; k < 16; k++) f[k] = 1'b0;
        return f;
    endfunction

    task automatic wait_start(input int bound, output logic found, output int t);
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                t     = cyc;
                break;
            end
        end
    endtask

    // Called on the first negedge of a start bit; returns on the last negedge of the frame.
    task automatic capture_frame(output logic [15:0] bits, output logic busy_hi);
        bits    = '0;
        busy_hi = 1'b1;
        for (int rel = 0; rel < FRAME_CYC; rel++) begin
            if (rel > 0) @(negedge clk);
            if (tx_busy !== 1'b1) busy_hi = 1'b0;
            if (rel % D == D / 2) bits[rel / D] = tx;
        end
    endtask

    logic [7:0]  msg [9] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h31, 8'h32, 8'h33};
    logic [15:0] bits;
    logic        busy_hi, found;
    int          t0, t_prev, ovf_cnt;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf", fifo_overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte: one-cycle latency from write edge to start bit
`ifdef UART_TX_PARITY_EN
        d_in = 8'h07;
`else
        d_in = 8'h48;
`endif
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        check("single_empty_after_write", empty, 0);
        check("single_tx_still_idle", tx, 1);
        @(negedge clk);
        check("single_start_tx", tx, 0);
        check("single_start_busy", tx_busy, 1);
        capture_frame(bits, busy_hi);
`ifdef UART_TX_PARITY_EN
        check("single_frame_0x07", bits, 16'h0E0E);
`else
        check("single_frame_0x48", bits, 16'h0290);
`endif
        check("single_busy_len", busy_hi, 1);
        @(negedge clk);
        check("single_busy_fall", tx_busy, 0);
        check("single_tx_idle", tx, 1);
        repeat (3) @(negedge clk);

        // Stream "HELLO 123": back-to-back frames spaced exactly one frame apart
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    @(negedge clk);
                    wr_en = 1'b1;
                    d_in  = msg[i];
                end
                @(negedge clk);
                wr_en = 1'b0;
            end
            begin
                t_prev = 0;
                for (int i = 0; i < 9; i++) begin
                    wait_start(3 * FRAME_CYC, found, t0);
                    check($sformatf("stream_start_%0d", i), found, 1);
                    capture_frame(bits, busy_hi);
                    check($sformatf("stream_frame_%0d", i), bits, frame_of(msg[i]));
                    if (i > 0) check($sformatf("stream_spacing_%0d", i), t0 - t_prev, FRAME_CYC);
                    t_prev = t0;
                end
            end
        join
        @(negedge clk);
        check("stream_done_busy", tx_busy, 0);
        check("stream_done_empty", empty, 1);
        repeat (3) @(negedge clk);

        // Overflow: 19 writes, one popped immediately, 16 stored, two dropped
        ovf_cnt = 0;
        fork
            begin
                for (int i = 0; i <= 19; i++) begin
                    @(negedge clk);
                    if (i > 0 && fifo_overflow === 1'b1) ovf_cnt++;
                    wr_en = (i < 19);
                    d_in  = 8'h41;
                end
                check("ovf_full", full, 1);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (fifo_overflow === 1'b1) ovf_cnt++;
                end
                check("ovf_pulses", ovf_cnt, 2);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    wait_start(3 * FRAME_CYC, found, t0);
                    check($sformatf("ovf_start_%0d", i), found, 1);
                    capture_frame(bits, busy_hi);
                    check($sformatf("ovf_frame_%0d", i), bits, frame_of(8'h41));
                end
            end
        join
        check("ovf_empty_after", empty, 1);
        wait_start(2 * FRAME_CYC, found, t0);
        check("ovf_no_18th_frame", found, 0);

        // Reset during data bit 3 of 0x55 with 4 entries queued
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    wr_en = 1'b1;
                    d_in  = (i == 0) ? 8'h55 : 8'(i);
                end
                @(negedge clk);
                wr_en = 1'b0;
            end
            begin
                wait_start(3 * FRAME_CYC, found, t0);
                check("rstmid_start", found, 1);
                repeat ((1 + 3) * D + D / 2) @(negedge clk);
                check("rstmid_in_frame", tx_busy, 1);
                check("rstmid_queue_nonempty", empty, 0);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rstmid_tx", tx, 1);
                check("rstmid_busy", tx_busy, 0);
                check("rstmid_empty", empty, 1);
            end
        join
        wait_start(3 * FRAME_CYC, found, t0);
        check("rstmid_no_more_frames", found, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
